// File: rtl/sigdelay_mc_if.sv
// Streaming bus between the sample source, sigdelay_mc and the DAC/display path.
interface sigdelay_mc_if #(
    parameter int unsigned A_WIDTH  = 9,
    parameter int unsigned D_WIDTH  = 8,
    parameter int unsigned CHANNELS = 2
);
    logic                         in_valid;
    logic [1:0]                   mode;
    logic [CHANNELS*A_WIDTH-1:0]  delay;
    logic [CHANNELS*D_WIDTH-1:0]  in_data;
    logic                         out_valid;
    logic [CHANNELS*D_WIDTH-1:0]  out_data;
    logic [CHANNELS-1:0]          out_primed;

    modport master (
        output in_valid, mode, delay, in_data,
        input  out_valid, out_data, out_primed
    );

    modport slave (
        input  in_valid, mode, delay, in_data,
        output out_valid, out_data, out_primed
    );
endinterface

// File: rtl/sigdelay_mc.sv
// Multi-channel delay line with bypass / delay / feedback-echo modes, latency 2.
module sigdelay_mc #(
    parameter int unsigned A_WIDTH  = 9,
    parameter int unsigned D_WIDTH  = 8,
    parameter int unsigned CHANNELS = 2
) (
    input  logic         clk,
    input  logic         rst,
    sigdelay_mc_if.slave bus
);
    localparam int unsigned      DEPTH      = 1 << A_WIDTH;
    localparam logic [1:0]       MODE_DELAY = 2'd1;
    localparam logic [1:0]       MODE_ECHO  = 2'd2;
    localparam logic [A_WIDTH-1:0] FILL_MAX = A_WIDTH'(DEPTH - 1);

    // History RAM, never reset; stale contents are masked by fill.
    logic [D_WIDTH-1:0] mem [CHANNELS][DEPTH];

    logic [A_WIDTH-1:0] wr_ptr;
    logic [A_WIDTH-1:0] fill;

    // Stage 1 registers (accepted sample plus RAM read data)
    logic                v1;
    logic [1:0]          mode1;
    logic [A_WIDTH-1:0]  wp1;
    logic [D_WIDTH-1:0]  x1   [CHANNELS];
    logic [A_WIDTH-1:0]  dly1 [CHANNELS];
    logic [CHANNELS-1:0] pr1;
    logic [D_WIDTH-1:0]  rd1  [CHANNELS];

    // Stage 2 registers (result and the value just written back)
    logic                v2;
    logic [D_WIDTH-1:0]  y2 [CHANNELS];
    logic [D_WIDTH-1:0]  s2 [CHANNELS];
    logic [CHANNELS-1:0] pr2;

    logic                        out_valid_r;
    logic [CHANNELS*D_WIDTH-1:0] out_data_r;
    logic [CHANNELS-1:0]         out_primed_r;

    logic [A_WIDTH-1:0]  dly_in_c [CHANNELS];
    logic [D_WIDTH-1:0]  x_in_c   [CHANNELS];
    logic [A_WIDTH-1:0]  ra_c     [CHANNELS];
    logic [CHANNELS-1:0] primed_c;
    logic [D_WIDTH-1:0]  d_c      [CHANNELS];
    logic [D_WIDTH:0]    sum_c    [CHANNELS];
    logic [D_WIDTH-1:0]  y_c      [CHANNELS];
    logic [D_WIDTH-1:0]  s_c      [CHANNELS];

    assign bus.out_valid  = out_valid_r;
    assign bus.out_data   = out_data_r;
    assign bus.out_primed = out_primed_r;

    // Unpack inputs, form read addresses and the primed flags.
    always_comb begin
        primed_c = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            dly_in_c[k] = bus.delay[k*A_WIDTH +: A_WIDTH];
            x_in_c[k]   = bus.in_data[k*D_WIDTH +: D_WIDTH];
            ra_c[k]     = wr_ptr - dly_in_c[k];
            primed_c[k] = (fill >= dly_in_c[k]);
        end
    end

    // Select the delayed value and compute the output and write-back value.
    always_comb begin
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            d_c[k]   = '0;
            sum_c[k] = '0;
            y_c[k]   = x1[k];
            s_c[k]   = x1[k];
            if (!pr1[k])
                d_c[k] = '0;
            else if (dly1[k] == '0)
                d_c[k] = x1[k];
            else if (dly1[k] == A_WIDTH'(1) && v2)
                d_c[k] = s2[k];     // previous sample's write lands this same edge
            else
                d_c[k] = rd1[k];
            sum_c[k] = {1'b0, x1[k]} + {1'b0, d_c[k]};
            case (mode1)
                MODE_DELAY: begin
                    y_c[k] = d_c[k];
                    s_c[k] = x1[k];
                end
                MODE_ECHO: begin
                    y_c[k] = D_WIDTH'(sum_c[k] >> 1);
                    s_c[k] = D_WIDTH'(sum_c[k] >> 1);
                end
                default: begin
                    y_c[k] = x1[k];
                    s_c[k] = x1[k];
                end
            endcase
        end
    end

    // RAM synchronous read at accept and write-back from stage 2.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (bus.in_valid)
                rd1[k] <= mem[k][ra_c[k]];
            if (v1)
                mem[k][wp1] <= s_c[k];
        end
    end

    // Pointers, pipeline registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            fill         <= '0;
            v1           <= 1'b0;
            mode1        <= '0;
            wp1          <= '0;
            pr1          <= '0;
            v2           <= 1'b0;
            pr2          <= '0;
            out_valid_r  <= 1'b0;
            out_data_r   <= '0;
            out_primed_r <= '0;
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                x1[k]   <= '0;
                dly1[k] <= '0;
                y2[k]   <= '0;
                s2[k]   <= '0;
            end
        end else begin
            v1          <= bus.in_valid;
            v2          <= v1;
            out_valid_r <= v2;
            if (bus.in_valid) begin
                mode1  <= bus.mode;
                wp1    <= wr_ptr;
                pr1    <= primed_c;
                wr_ptr <= wr_ptr + A_WIDTH'(1);
                fill   <= (fill == FILL_MAX) ? fill : fill + A_WIDTH'(1);
                for (int unsigned k = 0; k < CHANNELS; k++) begin
                    x1[k]   <= x_in_c[k];
                    dly1[k] <= dly_in_c[k];
                end
            end
            if (v1) begin
                pr2 <= pr1;
                for (int unsigned k = 0; k < CHANNELS; k++) begin
                    y2[k] <= y_c[k];
                    s2[k] <= s_c[k];
                end
            end
            if (v2) begin
                out_primed_r <= pr2;
                for (int unsigned k = 0; k < CHANNELS; k++)
                    out_data_r[k*D_WIDTH +: D_WIDTH] <= y2[k];
            end
        end
    end
endmodule

// File: tb/tb_sigdelay_mc.sv
// Directed bench for sigdelay_mc: two instances (2ch/A9 and 1ch/A4).
module tb_sigdelay_mc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    sigdelay_mc_if #(.A_WIDTH(9), .D_WIDTH(8), .CHANNELS(2)) bus_a ();
    sigdelay_mc_if #(.A_WIDTH(4), .D_WIDTH(8), .CHANNELS(1)) bus_b ();

    sigdelay_mc #(.A_WIDTH(9), .D_WIDTH(8), .CHANNELS(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    sigdelay_mc #(.A_WIDTH(4), .D_WIDTH(8), .CHANNELS(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    always #5 clk = ~clk;

    // Vector table for dut_a: one entry per input cycle.
    logic        st_v [64];
    logic [1:0]  st_m [64];
    logic [17:0] st_d [64];
    logic [15:0] st_x [64];
    logic [15:0] ex_y [64];
    logic [1:0]  ex_p [64];
    int          n_vec = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
    endtask

    task automatic add(input logic v, input logic [1:0] m, input int d1, input int d0,
                       input int x1, input int x0, input int y1, input int y0,
                       input logic [1:0] p);
        st_v[n_vec] = v;
        st_m[n_vec] = m;
        st_d[n_vec] = {9'(d1), 9'(d0)};
        st_x[n_vec] = {8'(x1), 8'(x0)};
        ex_y[n_vec] = {8'(y1), 8'(y0)};
        ex_p[n_vec] = p;
        n_vec++;
    endtask

    // Play the table into dut_a; output for entry j is checked after step j+2.
    task automatic run(input string tag);
        logic [15:0] last;
        last = '0;
        for (int i = 0; i < n_vec + 2; i++) begin
            if (i < n_vec) begin
                bus_a.in_valid = st_v[i];
                bus_a.mode     = st_m[i];
                bus_a.delay    = st_d[i];
                bus_a.in_data  = st_x[i];
            end else begin
                bus_a.in_valid = 1'b0;
            end
            step();
            if (i >= 2 && st_v[i-2]) begin
                check($sformatf("%s[%0d].valid", tag, i-2), 32'(bus_a.out_valid), 32'(1));
                check($sformatf("%s[%0d].data", tag, i-2), 32'(bus_a.out_data), 32'(ex_y[i-2]));
                check($sformatf("%s[%0d].primed", tag, i-2), 32'(bus_a.out_primed), 32'(ex_p[i-2]));
                last = ex_y[i-2];
            end else begin
                check($sformatf("%s[%0d].idle", tag, i), 32'(bus_a.out_valid), 32'(0));
                check($sformatf("%s[%0d].hold", tag, i), 32'(bus_a.out_data), 32'(last));
            end
        end
        n_vec = 0;
    endtask

    initial begin
        bus_a.in_valid = 1'b0; bus_a.mode = '0; bus_a.delay = '0; bus_a.in_data = '0;
        bus_b.in_valid = 1'b0; bus_b.mode = '0; bus_b.delay = '0; bus_b.in_data = '0;

        // Reset state
        repeat (2) step();
        check("rst.valid_a",  32'(bus_a.out_valid),  32'(0));
        check("rst.data_a",   32'(bus_a.out_data),   32'(0));
        check("rst.primed_a", 32'(bus_a.out_primed), 32'(0));
        check("rst.valid_b",  32'(bus_b.out_valid),  32'(0));
        rst = 1'b0;
        step();

        // Delay mode: ch0 delay 3, ch1 delay 0
        do_reset();
        for (int i = 0; i < 10; i++)
            add(1'b1, 2'd1, 0, 3, 100 + i, i + 1, 100 + i, (i < 3) ? 0 : i - 2, {1'b1, i >= 3});
        run("delay");

        // Echo with delay 1, back-to-back (forwarding path)
        do_reset();
        add(1'b1, 2'd2, 0, 1, 10, 10, 10, 5,  2'b10);
        add(1'b1, 2'd2, 0, 1, 20, 20, 20, 12, 2'b11);
        add(1'b1, 2'd2, 0, 1, 30, 30, 30, 21, 2'b11);
        run("fwd");

        // Same with single-cycle gaps (RAM path)
        do_reset();
        add(1'b1, 2'd2, 0, 1, 10, 10, 10, 5,  2'b10);
        add(1'b0, 2'd2, 0, 1, 0, 0, 0, 0, 2'b00);
        add(1'b1, 2'd2, 0, 1, 20, 20, 20, 12, 2'b11);
        add(1'b0, 2'd2, 0, 1, 0, 0, 0, 0, 2'b00);
        add(1'b1, 2'd2, 0, 1, 30, 30, 30, 21, 2'b11);
        run("gap");

        // Mode switch bypass -> delay -> reserved -> delay
        do_reset();
        add(1'b1, 2'd0, 2, 1, 60, 50, 60, 50, 2'b00);
        add(1'b1, 2'd1, 2, 1, 80, 70, 0,  50, 2'b01);
        add(1'b1, 2'd3, 2, 1, 95, 90, 95, 90, 2'b11);
        add(1'b1, 2'd1, 2, 1, 2,  1,  80, 90, 2'b11);
        run("mode");

        // Echo saturation: full-scale input never wraps
        do_reset();
        add(1'b1, 2'd2, 0, 1, 255, 255, 255, 127, 2'b10);
        add(1'b1, 2'd2, 0, 1, 255, 255, 255, 191, 2'b11);
        add(1'b1, 2'd2, 0, 1, 255, 255, 255, 223, 2'b11);
        add(1'b1, 2'd2, 0, 1, 255, 255, 255, 239, 2'b11);
        add(1'b1, 2'd2, 0, 1, 255, 255, 255, 247, 2'b11);
        add(1'b1, 2'd2, 0, 1, 255, 255, 255, 251, 2'b11);
        run("sat");

        // Reset mid-stream with two samples in flight
        do_reset();
        bus_a.mode = 2'd0;
        bus_a.delay = '0;
        for (int i = 0; i < 3; i++) begin
            bus_a.in_valid = 1'b1;
            bus_a.in_data  = 16'(i + 1);
            step();
        end
        bus_a.in_valid = 1'b0;
        check("mid.valid_before", 32'(bus_a.out_valid), 32'(1));
        #2 rst = 1'b1;
        #1;
        check("mid.valid_async",  32'(bus_a.out_valid),  32'(0));
        check("mid.data_async",   32'(bus_a.out_data),   32'(0));
        check("mid.primed_async", 32'(bus_a.out_primed), 32'(0));
        repeat (2) step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("mid.drain[%0d]", i), 32'(bus_a.out_valid), 32'(0));
        end
        check("mid.primed_after", 32'(bus_a.out_primed), 32'(0));
        add(1'b1, 2'd1, 0, 1, 7, 9, 7, 0, 2'b10);
        run("post");

        // Max delay and pointer wrap on the 16-entry instance
        do_reset();
        bus_b.mode  = 2'd1;
        bus_b.delay = 4'd15;
        for (int i = 0; i < 53; i++) begin
            bus_b.in_valid = (i < 51);
            bus_b.in_data  = 8'(i);
            step();
            if (i >= 2) begin
                check($sformatf("wrap[%0d].valid", i-2), 32'(bus_b.out_valid), 32'(1));
                check($sformatf("wrap[%0d].data", i-2), 32'(bus_b.out_data),
                      32'((i - 2 >= 15) ? i - 17 : 0));
                check($sformatf("wrap[%0d].primed", i-2), 32'(bus_b.out_primed),
                      32'(i - 2 >= 15));
            end
        end
        bus_b.in_valid = 1'b0;
        step();
        check("wrap.idle", 32'(bus_b.out_valid), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
